// File: rtl/reg_mw_pkg.sv
// reg_mw_pkg: core-wide pipeline constants and the MEM/WB field bundle
package reg_mw_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [XLEN-1:0]   alu_data;
        logic [XLEN-1:0]   load_data;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } mw_bundle;
endpackage

// File: rtl/reg_mw.sv
// reg_mw: MEM/WB pipeline register with stall, flush and pre-muxed writeback data
module reg_mw #(
    parameter int XLEN   = reg_mw_pkg::XLEN,
    parameter int REG_AW = reg_mw_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   alu_data_in,
    input  logic [XLEN-1:0]   load_data_in,
    input  logic [REG_AW-1:0] dest_reg_addr_in,
    input  logic              write_enable_in,
    input  logic              load_enable_in,
    output logic [XLEN-1:0]   alu_data_out,
    output logic [XLEN-1:0]   load_data_out,
    output logic [REG_AW-1:0] dest_reg_addr_out,
    output logic              write_enable_out,
    output logic              load_enable_out,
    output logic [XLEN-1:0]   wb_data_out
);
    typedef struct packed {
        logic [XLEN-1:0]   alu_data;
        logic [XLEN-1:0]   load_data;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } bundle_t;

    bundle_t d, q;

    // x0 is hardwired to zero, so a write to it is dropped here once for all consumers
    always_comb begin
        d.alu_data  = alu_data_in;
        d.load_data = load_data_in;
        d.rd        = dest_reg_addr_in;
        d.we        = write_enable_in && (dest_reg_addr_in != '0);
        d.ld        = load_enable_in;
    end

    always_ff @(posedge clk)
        if (!rst_n || flush)
            q <= '0;
        else if (!stall)
            q <= d;

    assign alu_data_out      = q.alu_data;
    assign load_data_out     = q.load_data;
    assign dest_reg_addr_out = q.rd;
    assign write_enable_out  = q.we;
    assign load_enable_out   = q.ld;
    assign wb_data_out       = q.ld ? q.load_data : q.alu_data;
endmodule

// File: tb/tb_reg_mw.sv
// tb_reg_mw: table-driven and random-stream checks of reg_mw through an expected-value queue
module tb_reg_mw;
    logic        clk = 0;
    logic        rst_n, stall, flush;
    logic [31:0] alu_data_in, load_data_in;
    logic [4:0]  dest_reg_addr_in;
    logic        write_enable_in, load_enable_in;
    logic [31:0] alu_data_out, load_data_out, wb_data_out;
    logic [4:0]  dest_reg_addr_out;
    logic        write_enable_out, load_enable_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n, stall, flush;
        logic [31:0] alu, load;
        logic [4:0]  rd;
        logic        we, ld;
        logic [31:0] e_alu, e_load;
        logic [4:0]  e_rd;
        logic        e_we, e_ld;
    } vec_t;

    typedef struct {
        logic [31:0] alu, load, wb;
        logic [4:0]  rd;
        logic        we, ld;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_mw dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .flush(flush),
        .alu_data_in(alu_data_in),
        .load_data_in(load_data_in),
        .dest_reg_addr_in(dest_reg_addr_in),
        .write_enable_in(write_enable_in),
        .load_enable_in(load_enable_in),
        .alu_data_out(alu_data_out),
        .load_data_out(load_data_out),
        .dest_reg_addr_out(dest_reg_addr_out),
        .write_enable_out(write_enable_out),
        .load_enable_out(load_enable_out),
        .wb_data_out(wb_data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n = v.rst_n; stall = v.stall; flush = v.flush;
        alu_data_in = v.alu; load_data_in = v.load; dest_reg_addr_in = v.rd;
        write_enable_in = v.we; load_enable_in = v.ld;
        e.alu = v.e_alu; e.load = v.e_load; e.rd = v.e_rd; e.we = v.e_we; e.ld = v.e_ld;
        e.wb = v.e_ld ? v.e_load : v.e_alu;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sb.pop_front();
            check("alu_data_out", alu_data_out, e.alu);
            check("load_data_out", load_data_out, e.load);
            check("dest_reg_addr_out", 32'(dest_reg_addr_out), 32'(e.rd));
            check("write_enable_out", 32'(write_enable_out), 32'(e.we));
            check("load_enable_out", 32'(load_enable_out), 32'(e.ld));
            check("wb_data_out", wb_data_out, e.wb);
        end
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        alu_data_in = 0; load_data_in = 0; dest_reg_addr_in = 0;
        write_enable_in = 0; load_enable_in = 0;
        //         rst st fl alu           load          rd     we ld   e_alu         e_load        e_rd   ewe eld
        tbl.push_back('{0, 0, 0, 32'hDEADBEEF, 32'h12345678, 5'd5,  1, 1, 32'h0,        32'h0,        5'd0,  0, 0});
        tbl.push_back('{0, 0, 0, 32'hDEADBEEF, 32'h12345678, 5'd5,  1, 1, 32'h0,        32'h0,        5'd0,  0, 0});
        tbl.push_back('{1, 0, 0, 32'hFFFFFFF6, 32'h000000AB, 5'h1F, 1, 0, 32'hFFFFFFF6, 32'h000000AB, 5'h1F, 1, 0});
        tbl.push_back('{1, 0, 0, 32'hFFFFFFF6, 32'h000000AB, 5'h1F, 1, 1, 32'hFFFFFFF6, 32'h000000AB, 5'h1F, 1, 1});
        tbl.push_back('{1, 0, 0, 32'h00000001, 32'h0,        5'd0,  1, 0, 32'h00000001, 32'h0,        5'd0,  0, 0});
        tbl.push_back('{1, 0, 0, 32'h11111111, 32'h0,        5'd3,  1, 0, 32'h11111111, 32'h0,        5'd3,  1, 0});
        tbl.push_back('{1, 1, 0, 32'h22222222, 32'h0,        5'd4,  1, 0, 32'h11111111, 32'h0,        5'd3,  1, 0});
        tbl.push_back('{1, 1, 0, 32'h22222222, 32'h0,        5'd4,  1, 0, 32'h11111111, 32'h0,        5'd3,  1, 0});
        tbl.push_back('{1, 1, 0, 32'h22222222, 32'h0,        5'd4,  1, 0, 32'h11111111, 32'h0,        5'd3,  1, 0});
        tbl.push_back('{1, 0, 0, 32'h22222222, 32'h0,        5'd4,  1, 0, 32'h22222222, 32'h0,        5'd4,  1, 0});
        tbl.push_back('{1, 0, 1, 32'h00000033, 32'h00000044, 5'd7,  1, 1, 32'h0,        32'h0,        5'd0,  0, 0});
        tbl.push_back('{1, 0, 0, 32'h00000055, 32'h00000066, 5'd7,  1, 1, 32'h00000055, 32'h00000066, 5'd7,  1, 1});
        tbl.push_back('{1, 1, 1, 32'h00000033, 32'h00000044, 5'd7,  1, 1, 32'h0,        32'h0,        5'd0,  0, 0});
        tbl.push_back('{1, 0, 0, 32'h00000077, 32'h00000088, 5'd9,  1, 1, 32'h00000077, 32'h00000088, 5'd9,  1, 1});
        tbl.push_back('{1, 1, 0, 32'hxxxxxxxx, 32'hxxxxxxxx, 5'bx,  1'bx, 1'bx, 32'h00000077, 32'h00000088, 5'd9, 1, 1});
        tbl.push_back('{0, 1, 0, 32'hxxxxxxxx, 32'hxxxxxxxx, 5'bx,  1'bx, 1'bx, 32'h0,      32'h0,        5'd0,  0, 0});
        tbl.push_back('{1, 0, 0, 32'h80000000, 32'hFFFFFF80, 5'd1,  0, 1, 32'h80000000, 32'hFFFFFF80, 5'd1,  0, 1});
        foreach (tbl[i]) step(tbl[i]);

        // mid-cycle input glitch must not be captured
        @(negedge clk);
        rst_n = 1; stall = 0; flush = 0;
        alu_data_in = 32'hAAAA5555; load_data_in = 32'h0; dest_reg_addr_in = 5'd2;
        write_enable_in = 1; load_enable_in = 0;
        @(posedge clk);
        #2 alu_data_in = 32'h5555AAAA;
        #2 alu_data_in = 32'hCAFEF00D;
        @(posedge clk);
        #1 check("glitch_alu", alu_data_out, 32'hCAFEF00D);

        for (int n = 0; n < 8; n++) begin
            v.rst_n = 1; v.stall = 0; v.flush = 0;
            v.alu = $urandom; v.load = $urandom;
            v.rd = 5'($urandom_range(0, 31));
            v.we = 1'($urandom_range(0, 1)); v.ld = 1'($urandom_range(0, 1));
            if (n == 0) v.rd = 5'd0;
            v.e_alu = v.alu; v.e_load = v.load; v.e_rd = v.rd;
            v.e_we = v.we && (v.rd != 5'd0); v.e_ld = v.ld;
            step(v);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
